// File: rtl/snn_core_param.sv
// snn_core_param: two-layer fully-connected binary-pixel inference core.
// N_IN pixels -> N_HID hidden units -> N_OUT outputs, argmax picks the digit.
// Weight ROMs and activation LUT are external, synchronous read, 1-cycle latency.
// Optional macro SNN_SAT_CNT_EN adds sat_cnt, a count of clamped activation indices.
// Handshake: start is sampled only in IDLE; busy is high from the accept edge until
// the edge that raises done; done is a 1-cycle pulse; digit/digit_score hold until
// the next done.
module snn_core_param #(
    parameter int N_IN    = 784,
    parameter int N_HID   = 32,
    parameter int N_OUT   = 10,
    parameter int W_W     = 8,
    parameter int ACC_W   = 26,
    parameter int FRAC_SH = 7,
    parameter int ACT_AW  = 11,
    localparam int IN_AW  = $clog2(N_IN),
    localparam int HID_AW = $clog2(N_HID),
    localparam int OUT_AW = $clog2(N_OUT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        q_input,
    output logic [IN_AW-1:0]            addr_input_unit,
    output logic [HID_AW+IN_AW-1:0]     addr_w_h,
    input  logic signed [W_W-1:0]       w_h,
    output logic [OUT_AW+HID_AW-1:0]    addr_w_o,
    input  logic signed [W_W-1:0]       w_o,
    output logic [ACT_AW-1:0]           act_addr,
    input  logic signed [W_W-1:0]       act_data,
    output logic                        busy,
    output logic                        done,
`ifdef SNN_SAT_CNT_EN
    output logic [15:0]                 sat_cnt,
`endif
    output logic [OUT_AW-1:0]           digit,
    output logic [W_W-1:0]              digit_score
);

    typedef enum logic [3:0] {
        S_IDLE, S_HID_MAC, S_HID_DRAIN, S_HID_ACT, S_HID_WR,
        S_OUT_MAC, S_OUT_DRAIN, S_OUT_ACT, S_OUT_CMP, S_DONE
    } state_t;

    // A lit pixel contributes the largest positive operand value.
    localparam logic signed [W_W-1:0]   A_ONE  = {1'b0, {(W_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACT_HI = ACC_W'((1 << (ACT_AW - 1)) - 1);
    localparam logic signed [ACC_W-1:0] ACT_LO = ~ACT_HI;

    state_t                   state, state_nxt;
    logic [IN_AW-1:0]         in_idx;
    logic [HID_AW-1:0]        hid_idx, hj_idx, hj_d;
    logic [OUT_AW-1:0]        out_idx;
    logic                     mac_vld;
    logic signed [ACC_W-1:0]  acc, acc_sum, shifted;
    logic signed [W_W-1:0]    hidden [N_HID];
    logic signed [W_W-1:0]    op_a, op_b, max_val;
    logic signed [2*W_W-1:0]  prod;
    logic [OUT_AW-1:0]        max_idx;
    logic                     clamp_hi, clamp_lo, clamp_q;
    logic [ACT_AW-1:0]        act_idx;
    logic                     in_last, hj_last, hid_last, out_last;

    assign in_last  = (in_idx  == IN_AW'(N_IN - 1));
    assign hj_last  = (hj_idx  == HID_AW'(N_HID - 1));
    assign hid_last = (hid_idx == HID_AW'(N_HID - 1));
    assign out_last = (out_idx == OUT_AW'(N_OUT - 1));

    assign addr_input_unit = in_idx;
    assign addr_w_h        = {hid_idx, in_idx};
    assign addr_w_o        = {out_idx, hj_idx};

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (start) state_nxt = S_HID_MAC;
            S_HID_MAC:   if (in_last) state_nxt = S_HID_DRAIN;
            S_HID_DRAIN: state_nxt = S_HID_ACT;
            S_HID_ACT:   state_nxt = S_HID_WR;
            S_HID_WR:    state_nxt = hid_last ? S_OUT_MAC : S_HID_MAC;
            S_OUT_MAC:   if (hj_last) state_nxt = S_OUT_DRAIN;
            S_OUT_DRAIN: state_nxt = S_OUT_ACT;
            S_OUT_ACT:   state_nxt = S_OUT_CMP;
            S_OUT_CMP:   state_nxt = out_last ? S_DONE : S_OUT_MAC;
            S_DONE:      state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // MAC operands arrive one cycle after their address; the drain cycle
    // still belongs to the layer whose MAC just finished.
    always_comb begin
        op_a = '0;
        op_b = '0;
        if (state == S_HID_MAC || state == S_HID_DRAIN) begin
            op_a = q_input ? A_ONE : '0;
            op_b = w_h;
        end else begin
            op_a = hidden[hj_d];
            op_b = w_o;
        end
        prod    = op_a * op_b;
        acc_sum = mac_vld ? acc + {{(ACC_W-2*W_W){prod[2*W_W-1]}}, prod} : acc;
    end

    // LUT index from the final sum: scale, clamp, then offset to unsigned
    // (offset by half the range is the same as flipping the index MSB).
    always_comb begin
        shifted  = acc_sum >>> FRAC_SH;
        clamp_hi = (shifted > ACT_HI);
        clamp_lo = (shifted < ACT_LO);
        act_idx  = {~shifted[ACT_AW-1], shifted[ACT_AW-2:0]};
        if (clamp_hi)      act_idx = '1;
        else if (clamp_lo) act_idx = '0;
    end

    // Datapath: counters, accumulator, hidden array, argmax and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_idx      <= '0;
            hid_idx     <= '0;
            hj_idx      <= '0;
            hj_d        <= '0;
            out_idx     <= '0;
            mac_vld     <= 1'b0;
            acc         <= '0;
            act_addr    <= '0;
            clamp_q     <= 1'b0;
            max_val     <= '0;
            max_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            digit       <= '0;
            digit_score <= '0;
`ifdef SNN_SAT_CNT_EN
            sat_cnt     <= '0;
`endif
            for (int k = 0; k < N_HID; k++) hidden[k] <= '0;
        end else begin
            mac_vld <= (state == S_HID_MAC) || (state == S_OUT_MAC);
            hj_d    <= hj_idx;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc  <= '0;
                        busy <= 1'b1;
`ifdef SNN_SAT_CNT_EN
                        sat_cnt <= '0;
`endif
                    end
                end
                S_HID_MAC: begin
                    acc    <= acc_sum;
                    in_idx <= in_last ? '0 : in_idx + 1'b1;
                end
                S_OUT_MAC: begin
                    acc    <= acc_sum;
                    hj_idx <= hj_last ? '0 : hj_idx + 1'b1;
                end
                S_HID_DRAIN, S_OUT_DRAIN: begin
                    acc      <= acc_sum;
                    act_addr <= act_idx;
                    clamp_q  <= clamp_hi | clamp_lo;
                end
                S_HID_ACT, S_OUT_ACT: begin
`ifdef SNN_SAT_CNT_EN
                    if (clamp_q && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
`endif
                end
                S_HID_WR: begin
                    hidden[hid_idx] <= act_data;
                    acc             <= '0;
                    hid_idx         <= hid_last ? '0 : hid_idx + 1'b1;
                end
                S_OUT_CMP: begin
                    // Strict compare: ties keep the lowest output index.
                    if (out_idx == '0 || act_data > max_val) begin
                        max_val <= act_data;
                        max_idx <= out_idx;
                    end
                    acc     <= '0;
                    out_idx <= out_last ? '0 : out_idx + 1'b1;
                end
                S_DONE: begin
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    digit       <= max_idx;
                    digit_score <= max_val;
                end
                default: ;
            endcase
        end
    end

endmodule
